eth_rs_link_fault_rx: RTL and testbench

Receive-side Reconciliation Sublayer link-fault monitor for 10GBASE-R. It consumes the 64-bit XGMII receive stream produced by the PHY and runs the IEEE 802.3 clause 46 link_fault state machine across both columns of each word. It reports local or remote fault status and the transmit-side reaction the MAC must take.

---
 rtl/eth_rs_pkg.sv | 32 +++
 rtl/eth_rs_fault_col_step.sv | 57 +++++
 rtl/eth_rs_link_fault_rx.sv | 101 ++++++++++
 tb/tb_eth_rs_link_fault_rx.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/eth_rs_pkg.sv
// rtl/eth_rs_pkg.sv - shared types, ordered-set constants and column classifier for the RS link-fault monitor
package eth_rs_pkg;

  typedef enum logic [1:0] {
    LINK_OK     = 2'd0,
    LINK_LOCAL  = 2'd1,
    LINK_REMOTE = 2'd2
  } link_fault_e;

  typedef enum logic [1:0] {
    SEQ_NONE   = 2'd0,
    SEQ_LOCAL  = 2'd1,
    SEQ_REMOTE = 2'd2
  } seq_type_e;

  localparam logic [7:0] XGMII_SEQ_OS = 8'h9C;
  localparam logic [7:0] LF_CODE      = 8'h01;
  localparam logic [7:0] RF_CODE      = 8'h02;

  // Only the exact local/remote fault ordered sets count; any other sequence set is ordinary traffic.
  function automatic seq_type_e classify_col(input logic [3:0] ctrl, input logic [31:0] data);
    classify_col = SEQ_NONE;
    if (ctrl == 4'b0001 && data[7:0] == XGMII_SEQ_OS && data[23:8] == 16'h0000) begin
      if (data[31:24] == LF_CODE) begin
        classify_col = SEQ_LOCAL;
      end else if (data[31:24] == RF_CODE) begin
        classify_col = SEQ_REMOTE;
      end
    end
  endfunction

endpackage

// File: rtl/eth_rs_fault_col_step.sv
// rtl/eth_rs_fault_col_step.sv - one-column step of the link_fault state machine
module eth_rs_fault_col_step
  import eth_rs_pkg::*;
#(
  parameter int FAULT_WINDOW    = 128,
  parameter int FAULT_THRESHOLD = 4,
  parameter int CNT_W           = $clog2(FAULT_WINDOW + 1),
  parameter int SEQ_W           = $clog2(FAULT_THRESHOLD + 1)
) (
  input  logic [3:0]       ctrl,
  input  logic [31:0]      data,
  input  seq_type_e        last_type_in,
  input  logic [SEQ_W-1:0] seq_cnt_in,
  input  logic [CNT_W-1:0] col_cnt_in,
  input  link_fault_e      link_fault_in,
  output seq_type_e        last_type_out,
  output logic [SEQ_W-1:0] seq_cnt_out,
  output logic [CNT_W-1:0] col_cnt_out,
  output link_fault_e      link_fault_out,
  output logic             is_fault
);

  localparam logic [SEQ_W-1:0] THR = SEQ_W'(FAULT_THRESHOLD);
  localparam logic [CNT_W-1:0] WIN = CNT_W'(FAULT_WINDOW);

  seq_type_e col_type;

  // Classify the column, then either advance the sequence count or age the quiet-column window.
  always_comb begin
    col_type       = classify_col(ctrl, data);
    is_fault       = (col_type != SEQ_NONE);
    last_type_out  = last_type_in;
    seq_cnt_out    = seq_cnt_in;
    col_cnt_out    = col_cnt_in;
    link_fault_out = link_fault_in;
    if (is_fault) begin
      col_cnt_out = '0;
      if (col_type == last_type_in) begin
        seq_cnt_out = (seq_cnt_in >= THR) ? THR : seq_cnt_in + 1'b1;
      end else begin
        last_type_out = col_type;
        seq_cnt_out   = SEQ_W'(1);
      end
      if (seq_cnt_out == THR) begin
        link_fault_out = (col_type == SEQ_LOCAL) ? LINK_LOCAL : LINK_REMOTE;
      end
    end else if (col_cnt_in >= WIN - 1'b1) begin
      col_cnt_out    = WIN;
      seq_cnt_out    = '0;
      last_type_out  = SEQ_NONE;
      link_fault_out = LINK_OK;
    end else begin
      col_cnt_out = col_cnt_in + 1'b1;
    end
  end

endmodule

// File: rtl/eth_rs_link_fault_rx.sv
// rtl/eth_rs_link_fault_rx.sv - 10GBASE-R receive RS link-fault monitor over two XGMII columns per word
module eth_rs_link_fault_rx
  import eth_rs_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int FAULT_WINDOW    = 128,
  parameter int FAULT_THRESHOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] xgmii_rxd,
  input  logic [CTRL_WIDTH-1:0] xgmii_rxc,
  output logic                  rx_local_fault,
  output logic                  rx_remote_fault,
  output logic                  rx_link_ok,
  output logic                  tx_send_remote_fault,
  output logic                  tx_send_idle,
  output logic [15:0]           rx_fault_seq_count
);

  localparam int CNT_W = $clog2(FAULT_WINDOW + 1);
  localparam int SEQ_W = $clog2(FAULT_THRESHOLD + 1);

  seq_type_e        last_type, last_type_0, last_type_1;
  logic [SEQ_W-1:0] seq_cnt, seq_cnt_0, seq_cnt_1;
  logic [CNT_W-1:0] col_cnt, col_cnt_0, col_cnt_1;
  link_fault_e      link_fault, link_fault_0, link_fault_1;
  logic             fault_0, fault_1;
  logic [16:0]      count_sum;
  logic [15:0]      count_next;

  // Column 0 (bytes 0..3) is evaluated first and its result feeds column 1 (bytes 4..7).
  eth_rs_fault_col_step #(
    .FAULT_WINDOW   (FAULT_WINDOW),
    .FAULT_THRESHOLD(FAULT_THRESHOLD)
  ) u_col0 (
    .ctrl          (xgmii_rxc[3:0]),
    .data          (xgmii_rxd[31:0]),
    .last_type_in  (last_type),
    .seq_cnt_in    (seq_cnt),
    .col_cnt_in    (col_cnt),
    .link_fault_in (link_fault),
    .last_type_out (last_type_0),
    .seq_cnt_out   (seq_cnt_0),
    .col_cnt_out   (col_cnt_0),
    .link_fault_out(link_fault_0),
    .is_fault      (fault_0)
  );

  eth_rs_fault_col_step #(
    .FAULT_WINDOW   (FAULT_WINDOW),
    .FAULT_THRESHOLD(FAULT_THRESHOLD)
  ) u_col1 (
    .ctrl          (xgmii_rxc[7:4]),
    .data          (xgmii_rxd[63:32]),
    .last_type_in  (last_type_0),
    .seq_cnt_in    (seq_cnt_0),
    .col_cnt_in    (col_cnt_0),
    .link_fault_in (link_fault_0),
    .last_type_out (last_type_1),
    .seq_cnt_out   (seq_cnt_1),
    .col_cnt_out   (col_cnt_1),
    .link_fault_out(link_fault_1),
    .is_fault      (fault_1)
  );

  // Up to two fault columns per word; the statistic sticks at all-ones.
  always_comb begin
    count_sum  = {1'b0, rx_fault_seq_count} + 17'(fault_0) + 17'(fault_1);
    count_next = count_sum[16] ? 16'hFFFF : count_sum[15:0];
  end

  // State and status flags register the end-of-word result so the flags stay one-hot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_type            <= SEQ_NONE;
      seq_cnt              <= '0;
      col_cnt              <= '0;
      link_fault           <= LINK_OK;
      rx_link_ok           <= 1'b1;
      rx_local_fault       <= 1'b0;
      rx_remote_fault      <= 1'b0;
      tx_send_remote_fault <= 1'b0;
      tx_send_idle         <= 1'b0;
      rx_fault_seq_count   <= '0;
    end else begin
      last_type            <= last_type_1;
      seq_cnt              <= seq_cnt_1;
      col_cnt              <= col_cnt_1;
      link_fault           <= link_fault_1;
      rx_link_ok           <= (link_fault_1 == LINK_OK);
      rx_local_fault       <= (link_fault_1 == LINK_LOCAL);
      rx_remote_fault      <= (link_fault_1 == LINK_REMOTE);
      tx_send_remote_fault <= (link_fault_1 == LINK_LOCAL);
      tx_send_idle         <= (link_fault_1 == LINK_REMOTE);
      rx_fault_seq_count   <= count_next;
    end
  end

endmodule

// File: tb/tb_eth_rs_link_fault_rx.sv
// tb/tb_eth_rs_link_fault_rx.sv - scoreboard bench for the RS link-fault monitor
module tb_eth_rs_link_fault_rx;

  localparam logic [31:0] D_IDLE = 32'h07070707;
  localparam logic [31:0] D_LF   = 32'h0100009C;
  localparam logic [31:0] D_RF   = 32'h0200009C;
  localparam logic [3:0]  C_IDLE = 4'hF;
  localparam logic [3:0]  C_SEQ  = 4'h1;
  localparam logic [1:0]  S_OK   = 2'd0;
  localparam logic [1:0]  S_LF   = 2'd1;
  localparam logic [1:0]  S_RF   = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] xgmii_rxd = {D_IDLE, D_IDLE};
  logic [7:0]  xgmii_rxc = 8'hFF;
  logic        rx_local_fault, rx_remote_fault, rx_link_ok;
  logic        tx_send_remote_fault, tx_send_idle;
  logic [15:0] rx_fault_seq_count;

  typedef struct {
    logic [1:0]  lf;
    logic [15:0] cnt;
    int          idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail = 0;
  int   widx = 0;

  eth_rs_link_fault_rx dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .xgmii_rxd           (xgmii_rxd),
    .xgmii_rxc           (xgmii_rxc),
    .rx_local_fault      (rx_local_fault),
    .rx_remote_fault     (rx_remote_fault),
    .rx_link_ok          (rx_link_ok),
    .tx_send_remote_fault(tx_send_remote_fault),
    .tx_send_idle        (tx_send_idle),
    .rx_fault_seq_count  (rx_fault_seq_count)
  );

  always #5 clk = ~clk;

  // Monitor: every word drives one registered result on the following edge.
  initial begin
    exp_t       e;
    logic [4:0] got, want;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e    = exp_q.pop_front();
        got  = {rx_link_ok, rx_local_fault, rx_remote_fault, tx_send_remote_fault, tx_send_idle};
        want = {e.lf == S_OK, e.lf == S_LF, e.lf == S_RF, e.lf == S_LF, e.lf == S_RF};
        n_assert++;
        if (got !== want) begin
          n_fail++;
          $display("FAIL status word %0d: got %b expected %b", e.idx, got, want);
        end
        n_assert++;
        if (rx_fault_seq_count !== e.cnt) begin
          n_fail++;
          $display("FAIL count word %0d: got %0d expected %0d", e.idx, rx_fault_seq_count, e.cnt);
        end
      end
    end
  end

  task automatic word(input logic [31:0] d0, input logic [3:0] c0,
                      input logic [31:0] d1, input logic [3:0] c1,
                      input logic [1:0] lf, input logic [15:0] cnt);
    exp_t e;
    @(negedge clk);
    xgmii_rxd = {d1, d0};
    xgmii_rxc = {c1, c0};
    e.lf  = lf;
    e.cnt = cnt;
    e.idx = widx;
    exp_q.push_back(e);
    widx++;
  endtask

  task automatic idle_word(input logic [1:0] lf, input logic [15:0] cnt);
    word(D_IDLE, C_IDLE, D_IDLE, C_IDLE, lf, cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    xgmii_rxd = {D_IDLE, D_IDLE};
    xgmii_rxc = 8'hFF;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_values(input string name);
    n_assert++;
    if ({rx_link_ok, rx_local_fault, rx_remote_fault, tx_send_remote_fault, tx_send_idle} !== 5'b10000) begin
      n_fail++;
      $display("FAIL %s flags: got %b expected 10000", name,
               {rx_link_ok, rx_local_fault, rx_remote_fault, tx_send_remote_fault, tx_send_idle});
    end
    n_assert++;
    if (rx_fault_seq_count !== 16'd0) begin
      n_fail++;
      $display("FAIL %s count: got %0d expected 0", name, rx_fault_seq_count);
    end
  endtask

  initial begin
    int guard;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle traffic keeps the link OK.
    for (int i = 0; i < 3; i++) idle_word(S_OK, 16'd0);

    // Local fault in column 0 of four words.
    for (int i = 1; i <= 4; i++)
      word(D_LF, C_SEQ, D_IDLE, C_IDLE, (i == 4) ? S_LF : S_OK, 16'(i));

    // Local fault in both columns: declared after the second word, then window behaviour.
    do_reset();
    word(D_LF, C_SEQ, D_LF, C_SEQ, S_OK, 16'd2);
    word(D_LF, C_SEQ, D_LF, C_SEQ, S_LF, 16'd4);
    for (int i = 0; i < 63; i++) idle_word(S_LF, 16'd4);
    word(D_LF, C_SEQ, D_IDLE, C_IDLE, S_LF, 16'd5);
    for (int i = 1; i <= 64; i++) idle_word((i == 64) ? S_OK : S_LF, 16'd5);

    // Three local then four remote sequences: REMOTE only after the fourth remote.
    do_reset();
    for (int i = 1; i <= 3; i++) word(D_LF, C_SEQ, D_IDLE, C_IDLE, S_OK, 16'(i));
    for (int i = 4; i <= 7; i++)
      word(D_RF, C_SEQ, D_IDLE, C_IDLE, (i == 7) ? S_RF : S_OK, 16'(i));

    // Direct switch LOCAL to REMOTE without passing through OK.
    do_reset();
    for (int i = 1; i <= 4; i++)
      word(D_LF, C_SEQ, D_IDLE, C_IDLE, (i == 4) ? S_LF : S_OK, 16'(i));
    for (int i = 5; i <= 8; i++)
      word(D_RF, C_SEQ, D_IDLE, C_IDLE, (i == 8) ? S_RF : S_LF, 16'(i));

    // Mixed pair restarts the sequence count at 1 as REMOTE.
    do_reset();
    word(D_LF, C_SEQ, D_RF, C_SEQ, S_OK, 16'd2);
    word(D_RF, C_SEQ, D_IDLE, C_IDLE, S_OK, 16'd3);
    word(D_RF, C_SEQ, D_IDLE, C_IDLE, S_OK, 16'd4);
    word(D_RF, C_SEQ, D_IDLE, C_IDLE, S_RF, 16'd5);

    // Look-alike sequence ordered sets are not faults.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      word(32'h0300009C, C_SEQ, 32'h0100019C, C_SEQ, S_OK, 16'd0);
      word(D_LF, 4'h3, D_RF, 4'h0, S_OK, 16'd0);
    end

    // Asynchronous reset in the middle of a LOCAL fault.
    do_reset();
    for (int i = 1; i <= 4; i++)
      word(D_LF, C_SEQ, D_IDLE, C_IDLE, (i == 4) ? S_LF : S_OK, 16'(i));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(negedge clk);
    xgmii_rxd = {D_IDLE, D_IDLE};
    xgmii_rxc = 8'hFF;
    rst_n = 1'b1;
    idle_word(S_OK, 16'd0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    n_assert++;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
